// File: rtl/uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain
// UART transmitter sitting on the read side of the TX FIFO. Whenever the FIFO
// is non-empty it pops one byte and serializes it on tx as:
//   start bit (0), DATA_WIDTH data bits LSB first, [even parity], STOP_BITS x 1.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a PARITY bit (XOR of the data bits) follows the data bits
//   undefined -> no parity state or logic; DATA goes straight to STOP
//
// Parameters:
//   DATA_WIDTH   data bits per frame (must match the FIFO)
//   CLKS_PER_BIT clk cycles per serial bit, >= 2
//   STOP_BITS    1 or 2
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   fifo_empty FIFO empty flag (only looked at while idle)
//   fifo_dout  FIFO head data, valid one cycle after fifo_empty falls
//   fifo_rd_en FIFO pop strobe, high only during the single FETCH cycle
//   tx         serial line, idle high, registered
//   tx_busy    high whenever the FSM is not idle
//   tx_done    one-cycle pulse after the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_fifo_drain #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd5
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_en_q, rd_en_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic                    bit_end;

  // Last cycle of the current bit period.
  assign bit_end = (cnt_q == CNT_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (!fifo_empty) begin
          state_d = S_FETCH;
        end
      end

      // Pop cycle: fifo_dout is already valid, latch it and drive the start bit.
      S_FETCH: begin
        shift_d  = fifo_dout;
        tx_d     = 1'b0;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = S_START;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo_dout;
`endif
      end

      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // shift_q[0] is always the bit on the line, so the next one is shift_q[1].
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
          if (idx_q == IDX_DATA_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      // idx_q is reused to count stop bits.
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_STOP_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Flag registers track the state register exactly.
    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

endmodule
